// File: rtl/ysyx_22041207_iter_mul.sv
// Iterative shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW.
// Signs are stripped on accept, one multiplier bit is retired per cycle, and the sign is reapplied at the end.
module ysyx_22041207_iter_mul #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_valid,
    input  logic            flush,
    input  logic            mulw,
    input  logic [1:0]      mul_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            mul_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);

    localparam int unsigned CntW  = $clog2(XLEN);
    localparam int unsigned HalfX = XLEN / 2;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     mcand_q, mplier_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [CntW-1:0]     cnt_q;
    logic                neg_q, word_q;

    logic                accept;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       sum;
    logic [2*XLEN-1:0]   acc_nxt, prod, prod_s;
    logic [XLEN-1:0]     res_hi, res_lo;

    assign accept = mul_valid & mul_ready & ~flush;

    // Operand magnitudes; 01 is unsigned, so b is treated as signed only under 11.
    always_comb begin
        a_neg = mul_signed[1] & a[XLEN-1];
        b_neg = (&mul_signed) & b[XLEN-1];
        a_mag = a_neg ? (~a + XLEN'(1)) : a;
        b_mag = b_neg ? (~b + XLEN'(1)) : b;
        if (mulw) begin
            a_neg = 1'b0;
            b_neg = 1'b0;
            a_mag = {{HalfX{1'b0}}, a[HalfX-1:0]};
            b_mag = {{HalfX{1'b0}}, b[HalfX-1:0]};
        end
    end

    // One iteration; after only HalfX iterations the product sits HalfX bits high.
    always_comb begin
        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (mcand_q[0] ? mplier_q : '0)};
        acc_nxt = {sum, acc_q[XLEN-1:1]};
        prod    = word_q ? (acc_nxt >> HalfX) : acc_nxt;
        prod_s  = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
        if (word_q) begin
            res_hi = '0;
            res_lo = {{HalfX{prod[HalfX-1]}}, prod[HalfX-1:0]};
        end else begin
            res_hi = prod_s[2*XLEN-1:XLEN];
            res_lo = prod_s[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StBusy;
            StBusy:  if (cnt_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_comb begin
        mul_ready = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            word_q    <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else if (accept) begin
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            acc_q    <= '0;
            cnt_q    <= mulw ? CntW'(HalfX - 1) : CntW'(XLEN - 1);
            neg_q    <= a_neg ^ b_neg;
            word_q   <= mulw;
        end else if (state_q == StBusy && !flush) begin
            acc_q   <= acc_nxt;
            mcand_q <= mcand_q >> 1;
            cnt_q   <= cnt_q - CntW'(1);
            if (cnt_q == '0) begin
                result_hi <= res_hi;
                result_lo <= res_lo;
            end
        end
    end

endmodule
